// File: rtl/memory_stage_block.sv
// Memory (MEM) stage of the 8-bit pipeline.
// Loads and stores target a 256 x 8 data memory through a one-entry posted
// write buffer. A load that hits the buffered address is forwarded from the
// buffer. The stage registers the write-back byte, the register-write field
// and a forwarding flag for the write-back stage.
module memory_stage_block (
  input  logic       clk,
  input  logic       reset,           // asynchronous, active-low
  input  logic [7:0] ans_ex,
  input  logic [7:0] data_out,
  input  logic       mem_en_ex,
  input  logic       mem_rw_ex,
  input  logic       mem_mux_sel_ex,
  input  logic [4:0] RW_ex,
  output logic [7:0] ans_mem,
  output logic [4:0] RW_mem,
  output logic       fwd_hit_mem
);

  localparam int unsigned DEPTH = 256;

  // Data memory and posted write buffer
  logic [7:0] mem_q [DEPTH];
  logic       wb_valid_q, wb_valid_d;
  logic [7:0] wb_addr_q,  wb_addr_d;
  logic [7:0] wb_data_q,  wb_data_d;

  // Pipeline output registers
  logic [7:0] ans_mem_q, ans_mem_d;
  logic [4:0] rw_mem_q,  rw_mem_d;
  logic       fwd_hit_q, fwd_hit_d;

  // Combinational read path
  logic       buf_match;
  logic       is_store;
  logic       hit;
  logic [7:0] rd_data;

  // Read path: the buffer shadows memory for its address, so a load right
  // behind a store sees the new value. A store reads the old content of its
  // address here, which gives read-before-write when it selects memory data.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    rd_data   = 8'h00;
    buf_match = wb_valid_q && (wb_addr_q == ans_ex);
    is_store  = mem_en_ex && mem_rw_ex;
    hit       = mem_en_ex && !mem_rw_ex && buf_match;
    if (mem_en_ex) begin
      rd_data = buf_match ? wb_data_q : mem_q[ans_ex];
    end
  end

  // Next-state: capture a new store into the buffer, select the write-back byte
  always_comb begin
    wb_valid_d = is_store;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (is_store) begin
      wb_addr_d = ans_ex;
      wb_data_d = data_out;
    end
    ans_mem_d = mem_mux_sel_ex ? rd_data : ans_ex;
    rw_mem_d  = RW_ex;
    fwd_hit_d = hit;
  end

  // Buffer and pipeline registers; a pending store is discarded on reset
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= 8'h00;
      wb_data_q  <= 8'h00;
      ans_mem_q  <= 8'h00;
      rw_mem_q   <= 5'b00000;
      fwd_hit_q  <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      ans_mem_q  <= ans_mem_d;
      rw_mem_q   <= rw_mem_d;
      fwd_hit_q  <= fwd_hit_d;
    end
  end

  // Memory array: the buffered store commits on the edge after it was captured
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the array must read as all zeros after reset, so it is built from
    // resettable flops rather than a RAM macro; this is intentional.
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wb_valid_q) begin
      mem_q[wb_addr_q] <= wb_data_q;
    end
  end

  assign ans_mem     = ans_mem_q;
  assign RW_mem      = rw_mem_q;
  assign fwd_hit_mem = fwd_hit_q;

endmodule
